// File: rtl/pc_gen.sv
// Fetch-address generator: boot delay, redirect epochs, valid/ready toward fetch.
// Define PC_BTB_EN to build the direct-mapped branch-target buffer.
module pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 4,
    parameter int                EPOCH_W   = 2,
    parameter int                BTB_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    input  logic [1:0]         halt_type_i,
    input  logic               fetch_ready_i,
    input  logic               btb_wr_i,
    input  logic [ADDR_W-1:0]  btb_wr_pc_i,
    input  logic [ADDR_W-1:0]  btb_wr_tgt_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               pc_valid_o,
    output logic [EPOCH_W-1:0] pc_epoch_o,
    output logic               pc_changed_o,
    output logic               predicted_o
);
    // state  | meaning
    // S_RST  | held in reset, pc_o = RESET_VEC, not valid
    // S_BOOT | one-cycle boot delay, inputs ignored
    // S_RUN  | normal operation, pc_o valid toward fetch
    localparam logic [1:0] S_RST  = 2'd0;
    localparam logic [1:0] S_BOOT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam int OFF_W = $clog2(STEP);

    logic [1:0]        state;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_tgt;
    logic              unused_lo;

    assign seq_pc    = pc_o + ADDR_W'(STEP);
    assign branch_pc = {branch_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign next_pc   = btb_hit ? btb_tgt : seq_pc;

`ifdef PC_BTB_EN
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_data [BTB_DEPTH];
    logic [IDX_W-1:0]     rd_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic [TAG_W-1:0]     wr_tag;

    assign rd_idx    = pc_o[OFF_W +: IDX_W];
    assign rd_tag    = pc_o[ADDR_W-1 -: TAG_W];
    assign wr_idx    = btb_wr_pc_i[OFF_W +: IDX_W];
    assign wr_tag    = btb_wr_pc_i[ADDR_W-1 -: TAG_W];
    assign btb_hit   = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
    assign btb_tgt   = btb_data[rd_idx];
    assign unused_lo = ^{branch_addr_i[OFF_W-1:0], btb_wr_pc_i[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (btb_wr_i) begin
            btb_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target need no reset: the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (rst && btb_wr_i) begin
            btb_tag[wr_idx]  <= wr_tag;
            btb_data[wr_idx] <= btb_wr_tgt_i;
        end
    end
`else
    assign btb_hit   = 1'b0;
    assign btb_tgt   = '0;
    assign unused_lo = ^{branch_addr_i[OFF_W-1:0], btb_wr_i, btb_wr_pc_i, btb_wr_tgt_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_RST;
            pc_o         <= RESET_VEC;
            pc_valid_o   <= 1'b0;
            pc_epoch_o   <= '0;
            pc_changed_o <= 1'b0;
            predicted_o  <= 1'b0;
        end else begin
            case (state)
                S_RST: begin
                    state        <= S_BOOT;
                    pc_changed_o <= 1'b0;
                end
                S_BOOT: begin
                    state        <= S_RUN;
                    pc_o         <= RESET_VEC;
                    pc_valid_o   <= 1'b1;
                    pc_changed_o <= 1'b0;
                end
                S_RUN: begin
                    if (branch_i) begin
                        pc_o         <= branch_pc;
                        pc_epoch_o   <= pc_epoch_o + 1'b1;
                        predicted_o  <= 1'b0;
                        pc_changed_o <= 1'b1;
                    end else if (halt_type_i != 2'b00) begin
                        pc_changed_o <= 1'b0;
                    end else if (pc_valid_o && fetch_ready_i) begin
                        pc_o         <= next_pc;
                        predicted_o  <= btb_hit;
                        pc_changed_o <= 1'b1;
                    end else begin
                        pc_changed_o <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_RST;
                    pc_valid_o   <= 1'b0;
                    pc_changed_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed literal checks plus randomized run
// against an arithmetic reference model; a second 8-bit instance checks wrap.
module tb_pc_gen;
    localparam int STEP  = 4;
    localparam int DEPTH = 8;
`ifdef PC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [1:0]  halt = 2'b00;
    logic        ready = 1'b0;
    logic        btb_wr = 1'b0;
    logic [31:0] btb_wr_pc = '0;
    logic [31:0] btb_wr_tgt = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  pc_epoch;
    logic        pc_changed;
    logic        predicted;

    logic        r8 = 1'b0;
    logic        b8 = 1'b0;
    logic [7:0]  ba8 = '0;
    logic        rdy8 = 1'b0;
    logic [7:0]  pc8;
    logic        valid8;
    logic [1:0]  epoch8;
    logic        changed8;
    logic        pred8;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .rst(rst), .branch_i(branch), .branch_addr_i(branch_addr),
        .halt_type_i(halt), .fetch_ready_i(ready), .btb_wr_i(btb_wr),
        .btb_wr_pc_i(btb_wr_pc), .btb_wr_tgt_i(btb_wr_tgt), .pc_o(pc),
        .pc_valid_o(pc_valid), .pc_epoch_o(pc_epoch), .pc_changed_o(pc_changed),
        .predicted_o(predicted)
    );

    pc_gen #(.ADDR_W(8)) u8 (
        .clk(clk), .rst(r8), .branch_i(b8), .branch_addr_i(ba8),
        .halt_type_i(2'b00), .fetch_ready_i(rdy8), .btb_wr_i(1'b0),
        .btb_wr_pc_i(8'h00), .btb_wr_tgt_i(8'h00), .pc_o(pc8),
        .pc_valid_o(valid8), .pc_epoch_o(epoch8), .pc_changed_o(changed8),
        .predicted_o(pred8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = in reset, 1 = boot cycle, 2 = running.
    int          m_phase = 0;
    logic [31:0] m_pc = '0;
    bit          m_valid = 1'b0;
    int          m_epoch = 0;
    bit          m_changed = 1'b0;
    bit          m_pred = 1'b0;
    bit          mv [DEPTH];
    int unsigned mtag [DEPTH];
    logic [31:0] mtgt [DEPTH];
    int          m_idx;
    bit          m_hit;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0; m_pc = '0; m_valid = 1'b0; m_epoch = 0;
            m_changed = 1'b0; m_pred = 1'b0;
            foreach (mv[i]) mv[i] = 1'b0;
        end else begin
            m_idx = (m_pc / STEP) % DEPTH;
            m_hit = BTB && mv[m_idx] && (mtag[m_idx] == m_pc / (STEP * DEPTH));
            if (btb_wr) begin
                mv[(btb_wr_pc / STEP) % DEPTH]   = 1'b1;
                mtag[(btb_wr_pc / STEP) % DEPTH] = btb_wr_pc / (STEP * DEPTH);
                mtgt[(btb_wr_pc / STEP) % DEPTH] = btb_wr_tgt;
            end
            if (m_phase == 0) begin
                m_phase = 1; m_changed = 1'b0;
            end else if (m_phase == 1) begin
                m_phase = 2; m_valid = 1'b1; m_pc = '0; m_changed = 1'b0;
            end else if (branch) begin
                m_pc = (branch_addr / STEP) * STEP;
                m_epoch = (m_epoch + 1) % 4;
                m_pred = 1'b0; m_changed = 1'b1;
            end else if (halt != 2'b00) begin
                m_changed = 1'b0;
            end else if (ready) begin
                m_pc = m_hit ? mtgt[m_idx] : m_pc + STEP;
                m_pred = m_hit; m_changed = 1'b1;
            end else begin
                m_changed = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", {31'b0, pc_valid}, {31'b0, m_valid});
            check("model_pc", pc, m_pc);
            check("model_epoch", {30'b0, pc_epoch}, 32'(m_epoch));
            check("model_changed", {31'b0, pc_changed}, {31'b0, m_changed});
            check("model_pred", {31'b0, predicted}, {31'b0, m_pred});
        end
    end

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);

        rst = 1'b1;
        @(negedge clk);
        check("boot_valid", {31'b0, pc_valid}, 32'd0);
        @(negedge clk);
        check("run_valid", {31'b0, pc_valid}, 32'd1);
        check("run_pc", pc, 32'h0);
        check("run_epoch", {30'b0, pc_epoch}, 32'd0);

        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("seq_pc", pc, 32'(i * 4));
            check("seq_changed", {31'b0, pc_changed}, 32'd1);
        end
        ready = 1'b0;
        @(negedge clk);
        check("hold_pc", pc, 32'h10);
        check("hold_changed", {31'b0, pc_changed}, 32'd0);

        halt = 2'b01; branch = 1'b1; branch_addr = 32'h103;
        @(negedge clk);
        check("redir_pc", pc, 32'h100);
        check("redir_epoch", {30'b0, pc_epoch}, 32'd1);
        check("redir_changed", {31'b0, pc_changed}, 32'd1);
        repeat (3) @(negedge clk);
        branch = 1'b0; halt = 2'b00;
        check("epoch_wrap", {30'b0, pc_epoch}, 32'd0);

        btb_wr = 1'b1; btb_wr_pc = 32'h8; btb_wr_tgt = 32'h40;
        @(negedge clk);
        btb_wr = 1'b0; branch = 1'b1; branch_addr = 32'h0;
        @(negedge clk);
        branch = 1'b0; ready = 1'b1;
        check("btb_start", pc, 32'h0);
        @(negedge clk);
        check("btb_pc4", pc, 32'h4);
        @(negedge clk);
        check("btb_pc8", pc, 32'h8);
        check("btb_pred8", {31'b0, predicted}, 32'd0);
        @(negedge clk);
        check("btb_next", pc, BTB ? 32'h40 : 32'hC);
        check("btb_pred", {31'b0, predicted}, BTB ? 32'd1 : 32'd0);
        @(negedge clk);
        check("btb_after", pc, BTB ? 32'h44 : 32'h10);
        check("btb_pred_after", {31'b0, predicted}, 32'd0);
        ready = 1'b0;

        branch = 1'b1; branch_addr = 32'h20;
        @(negedge clk);
        branch = 1'b0;
        check("mid_pc", pc, 32'h20);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_epoch", {30'b0, pc_epoch}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_boot_valid", {31'b0, pc_valid}, 32'd1);
        branch = 1'b1; branch_addr = 32'h4;
        @(negedge clk);
        branch = 1'b0; ready = 1'b1;
        @(negedge clk);
        check("miss_pc8", pc, 32'h8);
        @(negedge clk);
        check("miss_pcC", pc, 32'hC);
        check("miss_pred", {31'b0, predicted}, 32'd0);
        ready = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            branch = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0: branch_addr = $urandom();
                1: branch_addr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                default: branch_addr = 32'($urandom_range(0, 127));
            endcase
            halt = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ready = ($urandom_range(0, 3) != 0);
            btb_wr = ($urandom_range(0, 5) == 0);
            btb_wr_pc = 32'($urandom_range(0, 31) * 4);
            btb_wr_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 31) * 4);
            @(negedge clk);
        end
        rst = 1'b1; branch = 1'b0; halt = 2'b00; ready = 1'b0; btb_wr = 1'b0;
        chk_en = 1'b0;

        r8 = 1'b1;
        repeat (2) @(negedge clk);
        check("w8_valid", {31'b0, valid8}, 32'd1);
        b8 = 1'b1; ba8 = 8'hFE;
        @(negedge clk);
        b8 = 1'b0; rdy8 = 1'b1;
        check("w8_redir", {24'b0, pc8}, 32'hFC);
        @(negedge clk);
        rdy8 = 1'b0;
        check("w8_wrap", {24'b0, pc8}, 32'h00);
        check("w8_changed", {31'b0, changed8}, 32'd1);
        check("w8_epoch", {30'b0, epoch8}, 32'd1);
        check("w8_pred", {31'b0, pred8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised fetch-address generator that replaces the fixed 32-bit, +4 program counter in the front end. It adds a valid/ready handshake toward instruction fetch, and a one-cycle boot delay after reset. It adds a redirect epoch tag so fetch can discard stale responses, and an optional branch-target buffer that predicts taken branches. It sits ahead of the fetch/IF stage and takes redirects from EX and stall requests from the hazard/memory controller.

Parameters:
ADDR_W, 32, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
RESET_VEC, 0, PC value loaded at reset; must be STEP-aligned.
STEP, 4, sequential increment; power of two, at least 2.
EPOCH_W, 2, width of the redirect epoch counter.
BTB_DEPTH, 8, BTB entry count; power of two; used only with PC_BTB_EN.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-low (0 = reset).
branch_i  in  1  redirect request from EX.
branch_addr_i  in  ADDR_W  redirect target.
halt_type_i  in  2  00 = run; any other value = stall (hold PC).
fetch_ready_i  in  1  fetch accepts pc_o this cycle.
btb_wr_i  in  1  BTB update strobe.
btb_wr_pc_i  in  ADDR_W  PC of the resolved taken branch.
btb_wr_tgt_i  in  ADDR_W  target of the resolved taken branch.
pc_o  out  ADDR_W  current fetch address.
pc_valid_o  out  1  pc_o is valid for fetch.
pc_epoch_o  out  EPOCH_W  epoch of pc_o.
pc_changed_o  out  1  one-cycle pulse: pc_o took a new value this edge.
predicted_o  out  1  pc_o came from a BTB hit.

Behaviour:
- Reset (rst=0 at the edge): state=S_RST, pc_o=RESET_VEC, pc_valid_o=0, pc_epoch_o=0, pc_changed_o=0, predicted_o=0, all BTB valid bits cleared. Reset taken mid-operation discards everything, including any pending redirect.
- State S_RST: moves to S_BOOT on the first edge with rst=1.
- State S_BOOT: lasts exactly one cycle; pc_valid_o=0; inputs ignored except rst; then moves to S_RUN with pc_valid_o=1 and pc_o=RESET_VEC.
- State S_RUN, priority per edge:
  1. branch_i=1: pc_o<=branch_addr_i with the low log2(STEP) bits forced to 0; pc_epoch_o increments with wrap; predicted_o<=0; pc_changed_o<=1. A redirect overrides halt_type_i and fetch_ready_i.
  2. halt_type_i!=00: hold pc_o, epoch and predicted_o; pc_changed_o<=0.
  3. Accept (pc_valid_o & fetch_ready_i): pc_o<=next. next = BTB target on a hit (feature enabled), otherwise pc_o+STEP with wrap. pc_changed_o<=1.
  4. Otherwise: hold pc_o; pc_changed_o<=0.
- pc_valid_o stays 1 throughout S_RUN, including during stalls; fetch gates its requests on halt.
- Wrap-around: from PC = 2^ADDR_W−STEP, the next sequential value is 0.
- pc_changed_o is registered and asserts in the same cycle as the new pc_o value.

Optional Feature:
PC_BTB_EN
- Defined:
  - Direct-mapped BTB with BTB_DEPTH entries, each holding a valid bit, a tag and a target.
  - Index = pc[log2(STEP) +: log2(BTB_DEPTH)]; tag = the remaining upper bits.
  - The lookup is combinational on pc_o.
  - On an accept with a hit: next = stored target and predicted_o<=1. An accept without a hit sets predicted_o<=0.
  - btb_wr_i writes valid, tag and target at the edge.
  - A write and a lookup to the same index in the same cycle: the lookup sees the old contents.
- Undefined:
  - No BTB storage is built.
  - btb_* inputs are ignored.
  - predicted_o is tied to 0.

Test Plan:
- Reset and boot: hold rst=0 for 3 cycles, then release → pc_valid_o=0 for exactly one cycle after release, then pc_o=RESET_VEC(0), pc_valid_o=1, pc_epoch_o=0.
- Sequential run: fetch_ready_i=1, halt=00 for 4 cycles → pc_o=0,4,8,C,10 with pc_changed_o=1 each edge; with fetch_ready_i=0 the PC holds and pc_changed_o=0.
- Redirect during stall: halt=01 with branch_i=1, branch_addr_i=0x103 → next cycle pc_o=0x100, epoch 0→1, pc_changed_o=1; four redirects in total wrap the epoch back to 0.
- Wrap: ADDR_W=8, pc_o=0xFC, accept → pc_o=0x00.
- BTB (PC_BTB_EN): write pc=0x8 → tgt 0x40, then run from 0 → sequence 0,4,8,0x40 with predicted_o=1 only at 0x40; without the macro the sequence is 0,4,8,0xC.
- Reset mid-run at pc_o=0x20 with a BTB entry valid → pc_o=0, epoch=0, BTB miss on the earlier entry afterwards.
